conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_pkg.sv | 14 +
 rtl/conv_window_gen_line_fifo.sv | 31 +++
 rtl/conv_window_gen.sv | 131 +++++++++++++
 tb/tb_conv_window_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared parameters for the padding, window-generation and convolution stages.
package conv_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_W          = 226;  // 220 active columns + 6 padding columns
    localparam int DEF_H          = 220;
    localparam int DEF_K          = 7;

    // Counter width for a 0..n-1 index. Never returns less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_fifo.sv
// One-row delay line. It is addressed by column and mapped to block RAM.
// The read port is synchronous. It is given the column of the *next* pixel,
// so that pixel's data from the row above is already registered when the
// pixel is accepted. If the read and write addresses are the same, the read
// returns the old contents.
module line_fifo
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_W,
    parameter int ADDR_W     = cnt_width(DEF_W)
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // RAM has no reset so it can map onto block RAM; read-before-write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/conv_window_gen.sv
// Builds a sliding KxK window over a padded, row-major pixel stream.
// K-1 line FIFOs supply the pixels above the incoming one, and a KxK
// register array shifts left on every accepted pixel. A window is reported
// one cycle after the pixel at its bottom-right corner is accepted.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  W          = DEF_W,
    parameter int  H          = DEF_H,
    parameter int  K          = DEF_K,
    localparam int ROW_W      = cnt_width(H),
    localparam int COL_W      = cnt_width(W)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     pxl_in,
    output logic                      out_valid,
    output logic [K*K*DATA_WIDTH-1:0] win_out,
    output logic [ROW_W-1:0]          out_row,
    output logic [COL_W-1:0]          out_col,
    output logic                      frame_done
);

    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(W - 1);

    logic [ROW_W-1:0]      r;
    logic [COL_W-1:0]      c;
    logic [COL_W-1:0]      c_next;
    logic                  accept;
    logic                  row_end;
    logic                  win_ready;
    // tap[i] is the pixel for window row i at the current column.
    // tap[K-1] is the incoming pixel. The line FIFOs supply the rows above it.
    logic [DATA_WIDTH-1:0] tap [K];
    logic [DATA_WIDTH-1:0] win [K][K];

    assign accept    = in_valid & ~clear;
    assign row_end   = (c == COL_LAST);
    assign win_ready = (r >= ROW_FIRST) && (c >= COL_FIRST);
    assign tap[K-1]  = pxl_in;

    // Column the next accepted pixel will occupy; drives the RAM read address
    always_comb begin
        c_next = c;
        if (clear) begin
            c_next = '0;
        end else if (in_valid) begin
            c_next = row_end ? '0 : c + COL_W'(1);
        end
    end

    // Chain of row delays: FIFO g outputs the pixel from g+1 rows above
    for (genvar g = 0; g < K - 1; g++) begin : g_line
        line_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (W),
            .ADDR_W     (COL_W)
        ) u_line_fifo (
            .clk     (clk),
            .rd_addr (c_next),
            .rd_data (tap[K-2-g]),
            .wr_en   (accept),
            .wr_addr (c),
            .wr_data (tap[K-1-g])
        );
    end

    // Row/column position of the next pixel; clear restarts the frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r <= '0;
            c <= '0;
        end else if (clear) begin
            r <= '0;
            c <= '0;
        end else if (in_valid) begin
            c <= c_next;
            if (row_end) begin
                r <= (r == ROW_LAST) ? '0 : r + ROW_W'(1);
            end
        end
    end

    // Window strobe, frame-end pulse and top-left coordinates of the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            out_valid  <= accept & win_ready;
            frame_done <= accept & row_end & (r == ROW_LAST);
            if (accept & win_ready) begin
                out_row <= r - ROW_FIRST;
                out_col <= c - COL_FIRST;
            end
        end
    end

    // Window array: shift left by one column and load the new column at j=K-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win[i][j] <= win[i][j+1];
                end
                win[i][K-1] <= tap[i];
            end
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_row
        for (genvar j = 0; j < K; j++) begin : g_col
            assign win_out[(i*K+j)*DATA_WIDTH +: DATA_WIDTH] = win[i][j];
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen with W=8, H=8, K=3 and 16-bit pixels.
// A frame-image model predicts every output cycle by cycle.
// Hand-written literals pin the first windows and the window counts.
module tb_conv_window_gen;

    localparam int DW = 16;
    localparam int WD = 8;
    localparam int HT = 8;
    localparam int KS = 3;
    localparam int RW = $clog2(HT);
    localparam int CW = $clog2(WD);

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 clear = 1'b0;
    logic                 in_valid = 1'b0;
    logic [DW-1:0]        pxl_in = '0;
    logic                 out_valid;
    logic [KS*KS*DW-1:0]  win_out;
    logic [RW-1:0]        out_row;
    logic [CW-1:0]        out_col;
    logic                 frame_done;

    int errors = 0;
    int checks = 0;
    int win_count = 0;

    always #5 clk = ~clk;

    conv_window_gen #(
        .DATA_WIDTH (DW),
        .W          (WD),
        .H          (HT),
        .K          (KS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .pxl_in     (pxl_in),
        .out_valid  (out_valid),
        .win_out    (win_out),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Accepted pixels go into an image at their (row, col). A window is the
    // KxK block of that image whose bottom-right corner is the pixel just accepted.
    int   m_r = 0, m_c = 0;
    int   img [HT][WD];
    logic e_valid = 1'b0, e_done = 1'b0;
    int   e_row = 0, e_col = 0;
    int   e_win [KS*KS];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_r = 0; m_c = 0;
            e_valid = 1'b0; e_done = 1'b0;
            e_row = 0; e_col = 0;
            for (int k = 0; k < KS*KS; k++) e_win[k] = 0;
        end else if (clear) begin
            m_r = 0; m_c = 0;
            e_valid = 1'b0; e_done = 1'b0;
        end else if (in_valid) begin
            img[m_r][m_c] = int'(pxl_in);
            e_valid = (m_r >= KS-1) && (m_c >= KS-1);
            e_done  = (m_r == HT-1) && (m_c == WD-1);
            if (e_valid) begin
                e_row = m_r - (KS-1);
                e_col = m_c - (KS-1);
                for (int i = 0; i < KS; i++)
                    for (int j = 0; j < KS; j++)
                        e_win[i*KS+j] = img[e_row+i][e_col+j];
            end
            if (m_c == WD-1) begin
                m_c = 0;
                m_r = (m_r == HT-1) ? 0 : m_r + 1;
            end else begin
                m_c = m_c + 1;
            end
        end else begin
            e_valid = 1'b0; e_done = 1'b0;
        end
    end

    // Compare the DUT with the model 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("out_row", 32'(out_row), reset ? 32'd0 : 32'(e_row));
        chk("out_col", 32'(out_col), reset ? 32'd0 : 32'(e_col));
        if (e_valid || reset)
            for (int k = 0; k < KS*KS; k++)
                chk("win_out", 32'(win_out[k*DW +: DW]), reset ? 32'd0 : 32'(e_win[k]));
        if (out_valid) win_count++;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic v, input logic [DW-1:0] d);
        in_valid = v;
        pxl_in   = d;
        @(negedge clk);
    endtask

    // Pixel p of a frame is at (p/8, p%8). Its value is r*16 + c + base.
    task automatic send_pixels(input int base, input bit toggle, input int first, input int last);
        for (int p = first; p <= last; p++) begin
            send(1'b1, DW'((p / WD) * 16 + (p % WD) + base));
            if (toggle) send(1'b0, 16'hDEAD);
        end
        in_valid = 1'b0;
    endtask

    // Run at the negedge after the (2,2) pixel is accepted.
    task automatic check_first_window(input string nm, input int base);
        int lit [KS*KS];
        lit = '{'h00, 'h01, 'h02, 'h10, 'h11, 'h12, 'h20, 'h21, 'h22};
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_row"}, 32'(out_row), 32'd0);
        chk({nm, "_col"}, 32'(out_col), 32'd0);
        for (int k = 0; k < KS*KS; k++)
            chk({nm, "_elem"}, 32'(win_out[k*DW +: DW]), 32'(lit[k] + base));
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_done"}, 32'(frame_done), 32'd0);
        chk({nm, "_row"}, 32'(out_row), 32'd0);
        chk({nm, "_col"}, 32'(out_col), 32'd0);
        chk({nm, "_win"}, 32'(win_out == '0), 32'd1);
    endtask

    initial begin
        int base_cnt;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // Continuous stream, single frame
        base_cnt = win_count;
        send_pixels(0, 1'b0, 0, 17);
        chk("no_window_before_2_2", 32'(win_count - base_cnt), 32'd0);
        send_pixels(0, 1'b0, 18, 18);
        check_first_window("cont_first", 0);
        send_pixels(0, 1'b0, 19, 63);
        chk("cont_frame_done", 32'(frame_done), 32'd1);
        chk("cont_last_row", 32'(out_row), 32'd5);
        chk("cont_last_col", 32'(out_col), 32'd5);
        chk("cont_last_elem", 32'(win_out[8*DW +: DW]), 32'h77);
        chk("cont_count", 32'(win_count - base_cnt), 32'd36);

        // in_valid toggling 1,0
        base_cnt = win_count;
        send_pixels(0, 1'b1, 0, 63);
        chk("toggle_count", 32'(win_count - base_cnt), 32'd36);

        // Back-to-back frames; the second frame is offset by 0x80
        send_pixels(0, 1'b0, 0, 63);
        base_cnt = win_count;
        send_pixels('h80, 1'b0, 0, 17);
        chk("frame2_no_early_window", 32'(win_count - base_cnt), 32'd0);
        send_pixels('h80, 1'b0, 18, 18);
        check_first_window("frame2_first", 'h80);
        send_pixels('h80, 1'b0, 19, 63);
        chk("frame2_count", 32'(win_count - base_cnt), 32'd36);

        // Reset asserted at pixel (4,5), then a full frame
        send_pixels(0, 1'b0, 0, 36);
        in_valid = 1'b1;
        pxl_in   = 16'h45;
        reset    = 1'b1;
        #1;
        check_zero("reset_immediate");
        repeat (2) @(negedge clk);
        check_zero("reset_held");
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        base_cnt = win_count;
        send_pixels(0, 1'b0, 0, 18);
        check_first_window("after_reset_first", 0);
        send_pixels(0, 1'b0, 19, 63);
        chk("after_reset_count", 32'(win_count - base_cnt), 32'd36);

        // Clear at pixel (3,3) with in_valid held high
        send_pixels(0, 1'b0, 0, 26);
        clear = 1'b1;
        send(1'b1, 16'h33);
        clear = 1'b0;
        chk("clear_out_valid", 32'(out_valid), 32'd0);
        base_cnt = win_count;
        send_pixels(0, 1'b0, 0, 18);
        chk("clear_first_only", 32'(win_count - base_cnt), 32'd1);
        check_first_window("clear_first", 0);
        send_pixels(0, 1'b0, 19, 63);
        chk("clear_count", 32'(win_count - base_cnt), 32'd36);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
